// File: rtl/ledtest_pio_blink_if.sv
// Avalon-MM slave bus bundle for ledtest_pio_blink: word address, select,
// active-low write strobe, write data and combinational read data.
interface ledtest_pio_blink_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );
endinterface

// File: rtl/ledtest_pio_blink.sv
// Output PIO with atomic set/clear and a per-bit blink engine sharing one half-period.
// Define LEDTEST_PIO_BLINK_EN to build the blink engine; otherwise out_port follows DATA.
module ledtest_pio_blink #(
   parameter int          WIDTH        = 8,
   parameter int          PERIOD_W     = 26,
   parameter logic [31:0] RESET_VALUE  = 32'd0,
   parameter logic [31:0] PERIOD_RESET = 32'd25000000
) (
   input  logic                 clk,
   input  logic                 reset,
   ledtest_pio_blink_if.slave   bus,
   output logic [WIDTH-1:0]     out_port
);

   localparam logic [2:0] A_DATA   = 3'd0;
   localparam logic [2:0] A_BLINK  = 3'd1;
   localparam logic [2:0] A_PERIOD = 3'd2;
   localparam logic [2:0] A_STATUS = 3'd3;
   localparam logic [2:0] A_OUTSET = 3'd4;
   localparam logic [2:0] A_OUTCLR = 3'd5;

   logic             wr;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             unused_wd;

   assign wr        = bus.chipselect & ~bus.write_n;
   assign unused_wd = ^bus.writedata;

   always_comb begin
      data_d = data_q;
      if (wr) begin
         case (bus.address)
            A_DATA:   data_d = bus.writedata[WIDTH-1:0];
            A_OUTSET: data_d = data_q | bus.writedata[WIDTH-1:0];
            A_OUTCLR: data_d = data_q & ~bus.writedata[WIDTH-1:0];
            default:  data_d = data_q;
         endcase
      end
   end

`ifdef LEDTEST_PIO_BLINK_EN
   localparam logic [PERIOD_W-1:0] P_ONE = PERIOD_W'(1);

   logic [WIDTH-1:0]    blink_q, blink_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic                phase_q, phase_d;

   always_comb begin
      blink_d  = blink_q;
      period_d = period_q;
      cnt_d    = cnt_q;
      phase_d  = phase_q;
      if (period_q == '0) begin
         cnt_d   = '0;
         phase_d = 1'b1;
      end else if (cnt_q == period_q - P_ONE) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end else begin
         cnt_d = cnt_q + P_ONE;
      end
      if (wr && bus.address == A_BLINK)
         blink_d = bus.writedata[WIDTH-1:0];
      // A PERIOD write restarts the half-period, winning over a coincident terminal count.
      if (wr && bus.address == A_PERIOD) begin
         period_d = bus.writedata[PERIOD_W-1:0];
         cnt_d    = '0;
         phase_d  = 1'b1;
      end
   end

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_out
      assign out_d[gi] = blink_q[gi] ? (data_q[gi] & phase_q) : data_q[gi];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         blink_q  <= '0;
         period_q <= PERIOD_RESET[PERIOD_W-1:0];
         cnt_q    <= '0;
         phase_q  <= 1'b1;
      end else begin
         blink_q  <= blink_d;
         period_q <= period_d;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
      end
   end

   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         A_DATA:   bus.readdata[WIDTH-1:0]    = data_q;
         A_BLINK:  bus.readdata[WIDTH-1:0]    = blink_q;
         A_PERIOD: bus.readdata[PERIOD_W-1:0] = period_q;
         A_STATUS: bus.readdata[1:0]          = {period_q != '0, phase_q};
         default:  bus.readdata               = '0;
      endcase
   end
`else
   assign out_d = data_q;

   always_comb begin
      bus.readdata = '0;
      if (bus.address == A_DATA)
         bus.readdata[WIDTH-1:0] = data_q;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= RESET_VALUE[WIDTH-1:0];
         out_q  <= RESET_VALUE[WIDTH-1:0];
      end else begin
         data_q <= data_d;
         out_q  <= out_d;
      end
   end

   assign out_port = out_q;

endmodule
